cpu_exec_ctrl: RTL
==================

Name: cpu_exec_ctrl

Overview:
Execution sequencer for the single-cycle CPU core, sitting between the UART command controller and the core's clock/reset inputs.
- Turns host commands (reset, step N, run, halt, breakpoint) into a shaped cpu_run pulse train and a cpu_reset level.
- Counts retired instructions and reports why the core stopped.
- One cpu_run high/low pair equals one executed instruction.

Parameters:
- PULSE_W, 2: clk cycles cpu_run stays high, and then low, per instruction (≥1).
- RESET_CYCLES, 4: clk cycles cpu_reset is held after a RESET command or the end of module reset (≥1).
- CNT_W, 32: width of the step counter and the instr_count counter.

Ports:
- clk  in  1  system clock (divided clock domain)
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command strobe, one cycle
- cmd_op  in  3  0 NOP, 1 RESET, 2 STEP, 3 RUN, 4 HALT, 5 SET_BP, 6 CLR_BP, 7 reserved
- cmd_arg  in  32  STEP count (low CNT_W bits) or SET_BP address
- cmd_ready  out  1  always 1; every command is consumed in the cycle it is presented
- pc  in  32  current CPU program counter
- cpu_run  out  1  CPU clock pulse train
- cpu_reset  out  1  CPU reset, active high
- halted  out  1  1 when in HALTED
- halt_reason  out  2  0 RESET, 1 STEP_DONE, 2 BREAKPOINT, 3 HOST
- instr_count  out  CNT_W  instructions retired since the last RESET; saturates at max
- done_pulse  out  1  one-cycle strobe on every entry to HALTED
- cmd_err  out  1  one-cycle strobe when a command is rejected

Behaviour:
Reset values (async, while reset=1):
- cpu_run=0, cpu_reset=1, halted=0, halt_reason=0, instr_count=0, done_pulse=0, cmd_err=0.
- bp_en=0, bp_addr=0, state=RST_HOLD.

States: RST_HOLD, HALTED, PULSE_HI, PULSE_LO.
- RST_HOLD:
  - cpu_reset=1; counts RESET_CYCLES clk cycles.
  - Then goes to HALTED with halt_reason=RESET, done_pulse=1, cpu_reset=0.
- HALTED: cpu_run=0; accepts every command.
  - RESET: instr_count←0, go to RST_HOLD.
  - STEP with arg≠0: remaining←arg, mode=STEP, first←1, go to PULSE_HI.
  - STEP with arg=0: cmd_err=1, stay in HALTED.
  - RUN: mode=RUN, first←1, go to PULSE_HI.
  - HALT, NOP: no effect.
  - Reserved opcode: cmd_err.
- Breakpoint check on entry to PULSE_HI: if bp_en and pc==bp_addr and first==0, do not pulse; go to HALTED with reason BREAKPOINT. The first pulse after a STEP/RUN ignores the breakpoint, so execution can resume from a breakpoint.
- PULSE_HI: cpu_run=1 for PULSE_W cycles, first←0, then go to PULSE_LO.
- PULSE_LO: cpu_run=0 for PULSE_W cycles. On the last cycle:
  - instr_count+1, saturating.
  - STEP mode: remaining−1.
  - Next-state priority:
    1. pending HALT → HALTED, reason HOST.
    2. STEP mode and remaining reached 0 → HALTED, reason STEP_DONE.
    3. otherwise → PULSE_HI, which applies the breakpoint check.
- cpu_run is a registered output. No pulse is ever truncated: a HALT received in PULSE_HI or PULSE_LO sets halt_pend, which is honoured at the end of PULSE_LO.
- Commands in PULSE_HI / PULSE_LO:
  - HALT sets halt_pend.
  - SET_BP (bp_addr←cmd_arg, bp_en←1) and CLR_BP (bp_en←0) take effect immediately, in any state.
  - RESET aborts the current pulse: cpu_run←0 next cycle, go to RST_HOLD, halt_pend cleared.
  - STEP, RUN and reserved opcodes: cmd_err, ignored.
- halt_pend is cleared on every entry to HALTED.
- Latency: STEP 1 accepted in HALTED → cpu_run rises on the next clk; done_pulse occurs 2·PULSE_W+1 cycles after acceptance.
- Async reset asserted mid-pulse forces cpu_run=0 and cpu_reset=1 immediately.

Decomposition:
- Shared package: cmd_op encodings, halt_reason encodings, state encoding.
- Optional sub-module pulse_timer: a loadable down-counter with a terminal-count flag, reused for PULSE_W and RESET_CYCLES.
- Everything else stays in one module.

Test Plan:
- Module reset release, PULSE_W=2, RESET_CYCLES=4 → cpu_reset high for 4 cycles after release, then halted=1, halt_reason=0, one done_pulse.
- STEP 3 from HALTED → exactly 3 cpu_run pulses, each 2 high / 2 low; instr_count=3; halt_reason=1; done_pulse 13 cycles after acceptance.
- SET_BP 0x10, RUN, pc model advancing +4 per pulse from 0 → halt with pc=0x10 after 4 pulses, reason 2. RUN again → the pulse at 0x10 executes and the run continues.
- RUN, then HALT sent during the second cycle of PULSE_HI → current pulse completes its full high and low phases, then halted with reason 3 and no further pulses.
- STEP 0, reserved opcode 7, and RUN while running → cmd_err pulses each time; state and instr_count unchanged.
- RESET during PULSE_HI → cpu_run low next cycle, cpu_reset high for 4 cycles, instr_count=0, reason 0; an async reset mid-run gives cpu_run=0 combinationally on assertion.

Source files
------------

// File: rtl/cpu_exec_ctrl_pkg.sv
// cpu_exec_ctrl_pkg: command, halt-reason and state encodings shared by the execution sequencer
package cpu_exec_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_RESET, OP_STEP, OP_RUN, OP_HALT, OP_SET_BP, OP_CLR_BP, OP_RSVD
  } cmd_op_e;
  typedef enum logic [1:0] {HR_RESET, HR_STEP_DONE, HR_BREAKPOINT, HR_HOST} halt_reason_e;
  typedef enum logic [1:0] {ST_RST_HOLD, ST_HALTED, ST_PULSE_HI, ST_PULSE_LO} state_e;
endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// cpu_exec_ctrl_if: host command channel into the execution sequencer
// cmd_valid/cmd_op/cmd_arg: one-cycle command from the host; cmd_ready: always 1;
// cmd_err: one-cycle strobe when a command is rejected
interface cpu_exec_ctrl_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_ready;
  logic        cmd_err;
  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready, cmd_err);
  modport slave (input cmd_valid, cmd_op, cmd_arg, output cmd_ready, cmd_err);
endinterface

// File: rtl/cpu_exec_ctrl_pulse_timer.sv
// cpu_exec_ctrl_pulse_timer: loadable down-counter that stops at zero and flags terminal count
// clk/reset: clock, async active-high reset (loads RST_VAL); load/load_val: reload; tc: count is zero
module cpu_exec_ctrl_pulse_timer #(
  parameter int TW = 3,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          tc
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - TW'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: turns host commands into a shaped cpu_run pulse train and cpu_reset level
// clk/reset: clock, async active-high reset; bus: host command channel; pc: core program counter
// cpu_run/cpu_reset: core clock pulse and reset; halted/halt_reason/done_pulse: stop status
// instr_count: saturating count of instructions retired since the last RESET
module cpu_exec_ctrl
  import cpu_exec_ctrl_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  cpu_exec_ctrl_if.slave   bus,
  input  logic [31:0]      pc,
  output logic             cpu_run,
  output logic             cpu_reset,
  output logic             halted,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] instr_count,
  output logic             done_pulse
);
  localparam int TW = $clog2((PULSE_W > RESET_CYCLES ? PULSE_W : RESET_CYCLES) + 1);
  state_e state, state_n;
  halt_reason_e reason, reason_n;
  logic [CNT_W-1:0] rem, rem_n, ic_n, arg_cnt;
  logic [31:0] bp_addr, bp_addr_n;
  logic step_mode, step_n, first, first_n, halt_pend, hp_n, bp_en, bp_en_n, done_n, err_n;
  logic tc, load, cv, rst_cmd, halt_cmd, go, halt_now, last_step, bp_hit, stop;
  cmd_op_e op;
  assign op = cmd_op_e'(bus.cmd_op);
  assign cv = bus.cmd_valid;
  assign arg_cnt = bus.cmd_arg[CNT_W-1:0];
  assign rst_cmd = cv && op == OP_RESET;
  assign halt_cmd = cv && op == OP_HALT;
  assign go = cv && ((op == OP_STEP && arg_cnt != '0) || op == OP_RUN);
  assign halt_now = halt_pend | halt_cmd;
  assign last_step = step_mode && rem == CNT_W'(1);
  assign bp_hit = bp_en && pc == bp_addr && !first;
  assign stop = halt_now || last_step || bp_hit;
  assign err_n = cv && (op == OP_RSVD || ((op == OP_STEP || op == OP_RUN) &&
                 (state != ST_HALTED || (op == OP_STEP && arg_cnt == '0))));
  assign bus.cmd_ready = 1'b1;
  // Outputs decode straight from the state register so async reset clears cpu_run at once
  assign cpu_run = state == ST_PULSE_HI;
  assign cpu_reset = state == ST_RST_HOLD;
  assign halted = state == ST_HALTED;
  assign halt_reason = reason;
  // Every state change reloads the timer; a RESET during the hold restarts it
  assign load = state_n != state || rst_cmd;
  cpu_exec_ctrl_pulse_timer #(.TW(TW), .RST_VAL(TW'(RESET_CYCLES - 1))) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(state_n == ST_RST_HOLD ? TW'(RESET_CYCLES - 1) : TW'(PULSE_W - 1)),
    .tc(tc)
  );
  always_comb begin
    state_n = state;
    rem_n = rem;
    step_n = step_mode;
    first_n = first;
    hp_n = halt_pend;
    bp_en_n = bp_en;
    bp_addr_n = bp_addr;
    ic_n = instr_count;
    reason_n = reason;
    done_n = 1'b0;
    if (cv && op == OP_SET_BP) begin
      bp_en_n = 1'b1;
      bp_addr_n = bus.cmd_arg;
    end
    if (cv && op == OP_CLR_BP) bp_en_n = 1'b0;
    if (rst_cmd) begin
      state_n = ST_RST_HOLD;
      ic_n = '0;
      hp_n = 1'b0;
    end else begin
      case (state)
        ST_RST_HOLD: if (tc) begin
          state_n = ST_HALTED;
          reason_n = HR_RESET;
          done_n = 1'b1;
          hp_n = 1'b0;
        end
        ST_HALTED: if (go) begin
          state_n = ST_PULSE_HI;
          step_n = op == OP_STEP;
          rem_n = arg_cnt;
          first_n = 1'b1;
        end
        ST_PULSE_HI: begin
          hp_n = halt_now;
          if (tc) begin
            state_n = ST_PULSE_LO;
            first_n = 1'b0;
          end
        end
        default: begin
          hp_n = halt_now;
          if (tc) begin
            ic_n = instr_count + CNT_W'(instr_count != '1);
            rem_n = step_mode ? rem - CNT_W'(1) : rem;
            state_n = stop ? ST_HALTED : ST_PULSE_HI;
            reason_n = halt_now ? HR_HOST : last_step ? HR_STEP_DONE : bp_hit ? HR_BREAKPOINT : reason;
            done_n = stop;
            hp_n = 1'b0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_RST_HOLD;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      reason <= HR_RESET;
      rem <= '0;
      step_mode <= 1'b0;
      first <= 1'b0;
      halt_pend <= 1'b0;
      bp_en <= 1'b0;
      bp_addr <= '0;
      instr_count <= '0;
      done_pulse <= 1'b0;
      bus.cmd_err <= 1'b0;
    end else begin
      reason <= reason_n;
      rem <= rem_n;
      step_mode <= step_n;
      first <= first_n;
      halt_pend <= hp_n;
      bp_en <= bp_en_n;
      bp_addr <= bp_addr_n;
      instr_count <= ic_n;
      done_pulse <= done_n;
      bus.cmd_err <= err_n;
    end
endmodule
